// File: rtl/iter_div.sv
// iter_div: multi-cycle radix-2 restoring divider for the execute stage.
// Produces one quotient bit per clock for DIV (signed) and DIVU (unsigned),
// returning {remainder, quotient} for HI/LO.
//
// Optional feature macro: DIV_ZERO_DETECT_EN
//   defined   : a zero divisor finishes in two cycles with result 0, div_zero_o=1
//   undefined : a zero divisor runs the full iteration; div_zero_o is tied 0
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   signed_div_i 1 = signed divide, 0 = unsigned; sampled with start
//   opdata1_i    dividend; sampled with start
//   opdata2_i    divisor; sampled with start
//   start_i      request, held high until ready_o is seen
//   annul_i      abandon the operation in flight
//   result_o     {remainder, quotient}
//   ready_o      result valid
//   busy_o       state is not IDLE (stall request)
//   div_zero_o   divisor was zero (detect build only)
module iter_div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  // r_dvd starts as the dividend magnitude; each iteration shifts one
  // dividend bit out of the top and one quotient bit into the bottom, so
  // after WIDTH iterations it holds the quotient magnitude.
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH:0]     w_minuend;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [2*WIDTH-1:0] w_result;
  logic               w_latch;
  logic               w_iter;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;

  // Magnitude of an operand; in signed mode a negative value is negated
  // (two's complement, so the most negative value maps onto itself).
  function automatic logic [WIDTH-1:0] f_mag(input logic signed [WIDTH-1:0] a,
                                             input logic                    is_signed);
    logic signed [WIDTH-1:0] neg;
    neg = -a;
    return (is_signed && (a < 0)) ? neg : a;
  endfunction

  // Apply the sign correction to an unsigned magnitude, wrapping mod 2^WIDTH.
  function automatic logic [WIDTH-1:0] f_fix_sign(input logic [WIDTH-1:0] mag,
                                                  input logic             neg);
    logic signed [WIDTH-1:0] s_mag;
    s_mag = mag;
    return neg ? -s_mag : s_mag;
  endfunction

  assign w_mag1  = f_mag(opdata1_i, signed_div_i);
  assign w_mag2  = f_mag(opdata2_i, signed_div_i);
  assign w_latch = (r_state == S_IDLE) && start_i && !annul_i;
  assign w_iter  = (r_state == S_ON) && !annul_i;

  // One restoring step: the minuend is one bit wider than the divisor, and
  // whenever it is not below the divisor the difference fits in WIDTH bits.
  assign w_minuend  = {r_rem, r_dvd[WIDTH-1]};
  assign w_qbit     = (w_minuend >= {1'b0, r_dvs});
  assign w_rem_next = w_qbit ? (w_minuend[WIDTH-1:0] - r_dvs) : w_minuend[WIDTH-1:0];
  assign w_quo_next = {r_dvd[WIDTH-2:0], w_qbit};
  assign w_result   = {f_fix_sign(w_rem_next, r_neg_r), f_fix_sign(w_quo_next, r_neg_q)};

  // ---- datapath registers (operands and partial results, no reset) ----
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_dvd   <= w_mag1;
      r_dvs   <= w_mag2;
      r_rem   <= '0;
      r_neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
      r_neg_r <= signed_div_i & opdata1_i[WIDTH-1];
    end else if (w_iter) begin
      r_dvd <= w_quo_next;
      r_rem <= w_rem_next;
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic r_div_zero;
  assign div_zero_o = r_div_zero;
`else
  assign div_zero_o = 1'b0;
`endif

  // ---- control FSM with registered outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
      result_o <= '0;
`ifdef DIV_ZERO_DETECT_EN
      r_div_zero <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            busy_o <= 1'b1;
            r_cnt  <= '0;
`ifdef DIV_ZERO_DETECT_EN
            if (opdata2_i == '0) r_state <= S_BYZERO;
            else                 r_state <= S_ON;
`else
            r_state <= S_ON;
`endif
          end
        end
        S_BYZERO: begin
          if (annul_i) begin
            r_state <= S_IDLE;
            busy_o  <= 1'b0;
          end else begin
            r_state  <= S_END;
            ready_o  <= 1'b1;
            result_o <= '0;
`ifdef DIV_ZERO_DETECT_EN
            r_div_zero <= 1'b1;
`endif
          end
        end
        S_ON: begin
          // Annul wins over both iteration and completion.
          if (annul_i) begin
            r_state <= S_IDLE;
            busy_o  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_CNT) begin
              r_state  <= S_END;
              ready_o  <= 1'b1;
              result_o <= w_result;
            end
          end
        end
        S_END: begin
          if (annul_i || !start_i) begin
            r_state <= S_IDLE;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            r_div_zero <= 1'b0;
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          ready_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Testbench for iter_div at WIDTH=32: directed divides with hand-computed
// results, a reference model built on plain / and % arithmetic, annul and
// mid-operation reset scenarios.
module tb_iter_div;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_div;
  logic [W-1:0]   op1;
  logic [W-1:0]   op2;
  logic           start;
  logic           annul;
  logic [2*W-1:0] result;
  logic           ready;
  logic           busy;
  logic           dz;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*W-1:0] exp_res;
  logic           exp_dz;
  logic           exp_vld = 1'b0;

  iter_div #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .busy_o       (busy),
    .div_zero_o   (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: {div_zero, remainder, quotient} from magnitudes and / %.
  function automatic logic [64:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, qm, rm, q, r;
    logic na, nb;
    na = s && a[31];
    nb = s && b[31];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    if (mb == 32'd0) begin
`ifdef DIV_ZERO_DETECT_EN
      return {1'b1, 64'd0};
`else
      qm = 32'hFFFF_FFFF;
      rm = ma;
`endif
    end else begin
      qm = ma / mb;
      rm = ma % mb;
    end
    q = (na ^ nb) ? -qm : qm;
    r = na ? -rm : rm;
    return {1'b0, r, q};
  endfunction

  // Compare process: whenever a result is presented, it must match the model.
  always @(negedge clk) begin
    if (!rst && ready && exp_vld) begin
      check("model result", result, exp_res);
      check("model div_zero", 64'(dz), 64'(exp_dz));
    end
  end

  task automatic run_div(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] lit, input logic lit_dz);
    logic [64:0] m;
    int n;
    int lat;
    m       = model(s, a, b);
    exp_res = m[63:0];
    exp_dz  = m[64];
    exp_vld = 1'b1;
    lat     = m[64] ? 2 : W + 1;
    @(negedge clk);
    signed_div = s; op1 = a; op2 = b; start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        check({name, " busy after start"}, 64'(busy), 64'd1);
        check({name, " not ready early"}, 64'(ready), 64'd0);
      end
    end while (!ready && n < 100);
    check({name, " latency"}, 64'(n), 64'(lat));
    check({name, " literal result"}, result, lit);
    check({name, " literal div_zero"}, 64'(dz), 64'(lit_dz));
    // Operands wander while start is held; the result must not move.
    op1 = ~a; op2 = 32'd3; signed_div = ~s;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check({name, " ready held"}, 64'(ready), 64'd1);
    check({name, " result held"}, result, lit);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, " ready drop"}, 64'(ready), 64'd0);
    check({name, " busy drop"}, 64'(busy), 64'd0);
    exp_vld = 1'b0;
  endtask

  initial begin
    logic seen;
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset result", result, 64'd0);
    check("reset ready", 64'(ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset div_zero", 64'(dz), 64'd0);
    rst = 1'b0;

    run_div("u 100/7",       1'b0, 32'd100,        32'd7,          {32'd2, 32'd14}, 1'b0);
    run_div("s -7/2",        1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    run_div("s 7/-2",        1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD}, 1'b0);
    run_div("s min/-1",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000}, 1'b0);
    run_div("s -100/-7",     1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'd14}, 1'b0);
    run_div("u max/1",       1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF}, 1'b0);
    run_div("u 2^31/max",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'd0}, 1'b0);
    run_div("u 0/5",         1'b0, 32'd0,          32'd5,          {32'd0, 32'd0}, 1'b0);
`ifdef DIV_ZERO_DETECT_EN
    run_div("u 5/0",         1'b0, 32'd5,          32'd0,          64'd0, 1'b1);
    run_div("s -5/0",        1'b1, 32'hFFFF_FFFB,  32'd0,          64'd0, 1'b1);
`else
    run_div("u 5/0",         1'b0, 32'd5,          32'd0,          {32'd5, 32'hFFFF_FFFF}, 1'b0);
    run_div("s -5/0",        1'b1, 32'hFFFF_FFFB,  32'd0,          {32'hFFFF_FFFB, 32'd1}, 1'b0);
`endif

    // Annul on the 10th ON cycle.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("annul busy", 64'(busy), 64'd0);
    check("annul ready", 64'(ready), 64'd0);
    annul = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    check("annul never ready", 64'(seen), 64'd0);
    run_div("u 9/3 after annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);

    // Reset in the middle of an operation, with start still asserted.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd9; start = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid rst result", result, 64'd0);
    check("mid rst ready", 64'(ready), 64'd0);
    check("mid rst busy", 64'(busy), 64'd0);
    check("mid rst div_zero", 64'(dz), 64'd0);
    rst = 1'b0; start = 1'b0;
    run_div("u 100/7 after rst", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_div.md
# iter_div

Parametrised multi-cycle radix-2 restoring divider for the execute stage. It serves DIV/DIVU by returning a quotient and remainder to be written to HI/LO. It computes one quotient bit per clock. It exposes a start/ready handshake that the execute stage uses to raise a pipeline stall request, and it accepts an annul from the control logic to abandon an operation in flight. It replaces the single-cycle arithmetic path for division, which cannot meet timing at full width.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; any even value ≥ 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1_i  in  WIDTH  dividend; sampled with start.
- opdata2_i  in  WIDTH  divisor; sampled with start.
- start_i  in  1  request; held high by the execute stage until ready_o is seen.
- annul_i  in  1  abandon the current operation (branch flush or exception).
- result_o  out  2*WIDTH  {remainder, quotient}; remainder maps to HI, quotient to LO.
- ready_o  out  1  result valid.
- busy_o  out  1  state is not IDLE; feeds the stall request.
- div_zero_o  out  1  divisor was zero (DIV_ZERO_DETECT_EN only; otherwise tied 0).

## Operation
The block is a state machine with four states: IDLE, BYZERO, ON, END.

- **IDLE**
  - start_i=1 and annul_i=0: latch the operands and signed_div_i, then go to ON with cnt=0.
  - With the macro defined and opdata2_i=0: go to BYZERO instead of ON.
  - Otherwise remain in IDLE.
- **BYZERO**: on the next edge go to END with result 0 and div_zero_o=1.
- **ON**
  - annul_i=1: go to IDLE and discard the partial result.
  - Otherwise perform one iteration: shift the minuend left and bring in the next dividend bit MSB-first. If minuend ≥ |divisor|, subtract and shift 1 into the quotient; else shift 0. Then cnt++.
  - When cnt reaches WIDTH-1, the iteration completes and the state moves to END.
- **END**
  - ready_o=1 and result_o holds its value.
  - start_i=0: go to IDLE.
  - start_i=1: remain in END.
  - annul_i=1: go to IDLE.

Arithmetic rules:
- Signed mode divides magnitudes. Two's-complement negation is applied to negative operands at latch.
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
- All arithmetic wraps modulo 2^WIDTH. Hence -2^(WIDTH-1) / -1 gives quotient 0x80…0 and remainder 0.
- Unsigned mode applies no sign correction.

Reset values: ready_o=0, busy_o=0, div_zero_o=0, result_o=0, state=IDLE, cnt=0. rst overrides every other input, including in the middle of an operation.

## Timing
- All outputs are registered.
- Latency:
  - Start is sampled at edge E0.
  - Normal divide: ready_o rises after edge E(WIDTH), i.e. WIDTH+1 edges after start is first seen. That is 33 edges at WIDTH=32.
  - BYZERO path: ready_o rises after edge E1.
- busy_o rises after E0 and falls on the edge that returns the state to IDLE.
- Annul is acted on at the next edge, with priority over iteration and completion.
- The execute stage must hold opdata and start_i stable while stalled. The block ignores operand changes after E0.
- A new start is accepted only from IDLE. Back-to-back operations therefore need at least one cycle with start_i=0 between them.

## Configuration
- **DIV_ZERO_DETECT_EN defined**: a zero divisor takes the BYZERO path, finishing in 2 cycles with result_o=0 and div_zero_o=1.
- **DIV_ZERO_DETECT_EN undefined**: no zero check. A zero divisor runs the full WIDTH iterations:
  - the quotient magnitude comes out all ones;
  - the remainder magnitude equals the dividend magnitude;
  - sign correction then applies as normal;
  - div_zero_o is constant 0.

## Test plan
- Unsigned 100/7, WIDTH=32 → after 33 edges ready_o=1, quotient 14, remainder 2. ready_o stays 1 while start_i is held and drops one edge after start_i falls.
- Signed -7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 → quotient 0xFFFFFFFD, remainder 1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, no hang.
- Divisor 0, dividend 5:
  - With macro: ready_o after 2 edges, result 0, div_zero_o=1.
  - Without macro, unsigned: ready_o after 33 edges, quotient 0xFFFFFFFF, remainder 5.
- Annul asserted on the 10th ON cycle → busy_o=0 and ready_o never asserts. A following start of 9/3 then returns quotient 3, remainder 0.
- rst pulsed mid-operation → all outputs are 0 after that edge, and the next start completes normally.
